// File: rtl/seq_detect_prog.sv
// Programmable serial bit-sequence detector: runtime-loadable 1..MAX_LEN bit pattern, overlap/non-overlap, registered match pulse.
// Optional saturating match counter on port match_count when SEQDET_COUNT_EN is defined.
module seq_detect_prog #(
  parameter int                 MAX_LEN     = 8,
  parameter int                 DEF_LEN     = 6,
  parameter logic [MAX_LEN-1:0] DEF_PATTERN = 8'b0000_1001,
  parameter bit                 DEF_OVERLAP = 1'b0
`ifdef SEQDET_COUNT_EN
  , parameter int               CNT_W       = 16
`endif
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         din,
  input  logic                         din_valid,
  input  logic                         cfg_load,
  input  logic [MAX_LEN-1:0]           cfg_pattern,
  input  logic [$clog2(MAX_LEN+1)-1:0] cfg_len,
  input  logic                         cfg_overlap,
  output logic                         cfg_err,
  output logic                         dout
`ifdef SEQDET_COUNT_EN
  , output logic [CNT_W-1:0]           match_count
`endif
);

  localparam int LEN_W = $clog2(MAX_LEN+1);
  localparam logic [LEN_W:0] ONE_W = 1;

  logic [MAX_LEN-1:0] pat;
  logic [LEN_W-1:0]   len;
  logic               ovl;
  // Only MAX_LEN-1 past bits are ever compared; din supplies the newest window bit.
  logic [MAX_LEN-2:0] hist;
  logic [LEN_W-1:0]   fill;

  logic               len_ok;
  logic               primed;
  logic               hit;
  logic [MAX_LEN-1:0] window;
  logic [MAX_LEN-1:0] len_mask;

  // NOTE: every combinational output gets a default before any branch so no latch is inferred.
  always_comb begin
    len_ok   = (cfg_len != '0) && (cfg_len <= LEN_W'(MAX_LEN));
    window   = {hist, din};
    len_mask = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      len_mask[i] = (i < int'(len));
    end
    primed = (({1'b0, fill} + ONE_W) >= {1'b0, len});
    hit    = primed && (((window ^ pat) & len_mask) == '0);
  end

  // NOTE: state updates use non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      pat     <= DEF_PATTERN;
      len     <= LEN_W'(DEF_LEN);
      ovl     <= DEF_OVERLAP;
      hist    <= '0;
      fill    <= '0;
      dout    <= 1'b0;
      cfg_err <= 1'b0;
    end else begin
      dout    <= 1'b0;
      cfg_err <= 1'b0;
      if (cfg_load) begin
        if (len_ok) begin
          pat  <= cfg_pattern;
          len  <= cfg_len;
          ovl  <= cfg_overlap;
          hist <= '0;
          fill <= '0;
        end else begin
          cfg_err <= 1'b1;
        end
      end else if (din_valid) begin
        hist <= window[MAX_LEN-2:0];
        dout <= hit;
        // Non-overlap restarts the fill; overlap keeps it saturated at len.
        if (hit && !ovl) begin
          fill <= '0;
        end else if (fill != len) begin
          fill <= fill + LEN_W'(1);
        end
      end
    end
  end

`ifdef SEQDET_COUNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      match_count <= '0;
    end else if (cfg_load) begin
      if (len_ok) match_count <= '0;
    end else if (din_valid && hit && (match_count != '1)) begin
      match_count <= match_count + CNT_W'(1);
    end
  end
`endif

endmodule
